// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver for the simulation fixture: synchronizes the TX line, decodes frames and
// queues received bytes in a small FIFO behind a ready/valid stream.
module uart_rx_monitor #(
    parameter int unsigned ClkPerBit = 16,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         rx_i,
    output logic [7:0]                   byte_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         reading_byte_o,
    output logic                         frame_err_o,
    output logic                         overflow_o,
    output logic [$clog2(FifoDepth):0]   level_o
);

    localparam int unsigned CntW = $clog2(ClkPerBit);
    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam logic [CntW-1:0] HalfLoad = CntW'(ClkPerBit / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(ClkPerBit - 1);
    localparam logic [PtrW:0]   FullLvl  = (PtrW + 1)'(FifoDepth);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

    logic           rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]     warm_q;
    logic           armed_q;
    logic           fall;

    state_e         state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           busy_q;
    logic           ferr_q, ferr_d;
    logic           tick;
    logic           push;

    logic [7:0]     mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]  count_q, count_d;
    logic [7:0]     byte_q, byte_d;
    logic           ovf_q, ovf_d;
    logic           pop, full, push_ok;

    // armed_q only rises once the synchronizer holds a real post-reset 1, so a line held low
    // through reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            warm_q    <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            warm_q    <= {warm_q[0], 1'b1};
            armed_q   <= armed_q | (warm_q[1] & rx_sync_q);
        end
    end

    assign fall = armed_q & ~rx_sync_q & rx_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        tick    = (cnt_q == '0);
        case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    cnt_d   = HalfLoad;
                end
            end
            StStart: begin
                cnt_d = tick ? FullLoad : cnt_q - 1'b1;
                if (tick) begin
                    if (rx_sync_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        idx_d   = 3'd0;
                    end
                end
            end
            StData: begin
                cnt_d = tick ? FullLoad : cnt_q - 1'b1;
                if (tick) begin
                    shreg_d[idx_q] = rx_sync_q;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                cnt_d = tick ? FullLoad : cnt_q - 1'b1;
                if (tick) begin
                    if (rx_sync_q) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitIdle;
                    end
                end
            end
            StWaitIdle: begin
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            busy_q  <= (state_d != StIdle);
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        pop      = valid_o & ready_i;
        full     = (count_q == FullLvl);
        push_ok  = push & (~full | pop);
        ovf_d    = push & full & ~pop;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Head register: the incoming byte becomes head when it lands on the new read slot.
        byte_d = byte_q;
        if (count_d != '0) begin
            byte_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? shreg_q : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            byte_q   <= 8'h00;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= shreg_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            byte_q   <= byte_d;
            ovf_q    <= ovf_d;
        end
    end

    assign byte_o         = byte_q;
    assign valid_o        = (count_q != '0);
    assign level_o        = count_q;
    assign reading_byte_o = busy_q;
    assign frame_err_o    = ferr_q;
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: expected bytes go into a queue that a negedge monitor
// drains on every accepted handshake; timing points are checked inline.
module tb_uart_rx_monitor;

    localparam int unsigned Cpb   = 16;
    localparam int unsigned Depth = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] byte_o;
    logic       valid;
    logic       reading;
    logic       ferr;
    logic       ovf;
    logic [2:0] level;

    int tests = 0;
    int fails = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_rx_monitor #(
        .ClkPerBit (Cpb),
        .FifoDepth (Depth)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rx_i           (rx),
        .byte_o         (byte_o),
        .valid_o        (valid),
        .ready_i        (ready),
        .reading_byte_o (reading),
        .frame_err_o    (ferr),
        .overflow_o     (ovf),
        .level_o        (level)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected byte.
    always @(negedge clk) begin
        if (ferr) ferr_cnt++;
        if (ovf) ovf_cnt++;
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got %02h, expected none", byte_o);
            end else begin
                check("rx_byte", int'(byte_o), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "time limit exceeded");
    end

    // Starts and ends on a negedge; the line is left at the stop-bit value.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (Cpb) @(negedge clk);
        end
        rx = stop;
        repeat (Cpb) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge clk);
        #1 ready = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (valid && n < 40);
        ready = 1'b0;
        check("drain_bounded", int'(n < 40), 1);
        check("drain_level", int'(level), 0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int f0;
        int o0;
        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_byte", int'(byte_o), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(reading), 0);
        check("rst_ferr", int'(ferr), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_level", int'(level), 0);
        repeat (8) @(negedge clk);

        // Single byte with timeline checks
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (2) @(negedge clk);
                check("busy_E1", int'(reading), 0);
                @(negedge clk);
                check("busy_E2", int'(reading), 1);
                repeat (151) @(negedge clk);
                check("busy_E153", int'(reading), 1);
                check("valid_E153", int'(valid), 0);
                @(negedge clk);
                check("busy_E154", int'(reading), 0);
                check("valid_E154", int'(valid), 1);
                check("level_E154", int'(level), 1);
                check("byte_E154", int'(byte_o), 'hA5);
            end
        join
        drain();

        // Glitch rejection
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (7) @(negedge clk);
        check("glitch_busy_E9", int'(reading), 1);
        @(negedge clk);
        check("glitch_busy_E10", int'(reading), 0);
        repeat (20) @(negedge clk);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        check("glitch_level", int'(level), 0);

        // Framing error followed by a held break, then a clean byte
        f0 = ferr_cnt;
        fork
            send_frame(8'h3C, 1'b0);
            begin
                repeat (154) @(negedge clk);
                check("ferr_E153", int'(ferr), 0);
                @(negedge clk);
                check("ferr_E154", int'(ferr), 1);
                @(negedge clk);
                check("ferr_E155", int'(ferr), 0);
            end
        join
        repeat (40) @(negedge clk);
        check("break_busy", int'(reading), 1);
        check("break_level", int'(level), 0);
        rx = 1'b1;
        repeat (2 * Cpb) @(negedge clk);
        check("break_released", int'(reading), 0);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        repeat (4) @(negedge clk);
        check("ferr_count", ferr_cnt - f0, 1);
        check("ferr_level", int'(level), 1);
        drain();

        // Overflow: fifth byte is dropped
        o0 = ovf_cnt;
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        repeat (4) @(negedge clk);
        check("ovf_level", int'(level), 4);
        check("ovf_count", ovf_cnt - o0, 1);
        drain();

        // Full FIFO with a pop on the stop-sample edge
        o0 = ovf_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h55);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        check("full_level", int'(level), 4);
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (153) @(negedge clk);
                @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
                @(negedge clk);
                check("fullpop_level_E154", int'(level), 4);
                check("fullpop_ovf_E154", int'(ovf), 0);
            end
        join
        repeat (4) @(negedge clk);
        check("fullpop_ovf_count", ovf_cnt - o0, 0);
        drain();

        // Reset mid-frame with the line pulled low through reset
        rx = 1'b0;
        repeat (Cpb) @(negedge clk);
        rx = 1'b1;
        repeat (3 * Cpb + Cpb / 2) @(negedge clk);
        check("midframe_busy", int'(reading), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        check("inrst_busy", int'(reading), 0);
        check("inrst_valid", int'(valid), 0);
        check("inrst_byte", int'(byte_o), 0);
        check("inrst_level", int'(level), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        check("low_after_rst_busy", int'(reading), 0);
        check("low_after_rst_level", int'(level), 0);
        rx = 1'b1;
        repeat (2 * Cpb) @(negedge clk);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        check("post_rst_level", int'(level), 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
